cnt_stream_checker: RTL and testbench
=====================================

// Module: cnt_stream_checker
//
// PURPOSE
// - Downstream consumer of the free-running 8-bit test counter, receiving it looped back off-chip into uio_in.
// - Checks that successive sampled values increment by exactly 1 mod 2^WIDTH.
// - Acquires lock, then flags the first break in the sequence as a sticky fault.
// - Gives silicon bring-up a pass/fail indication of the counter/IO path without a logic analyser.
//
// PARAMETERS
// - WIDTH     8  data width of the checked stream
// - LOCK_CNT  4  consecutive +1 matches required to declare lock (>=1)
// - ERR_W     8  width of the error counter (optional feature only)
//
// PORTS
// - clk        in   1      clock
// - rst_n      in   1      reset, asynchronous, active-low
// - en         in   1      sample strobe; data_in is consumed on a rising clk edge with en=1
// - data_in    in   WIDTH  stream value under test
// - clear      in   1      synchronous restart of the checker; priority over en
// - locked     out  1      registered; 1 while in LOCKED
// - fault      out  1      registered; 1 while in FAULT (sticky)
// - err_pulse  out  1      registered; 1-cycle pulse per mismatching sample seen in LOCKED or FAULT
// - err_cnt    out  ERR_W  mismatch count (see CONFIGURATION)
//
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE, prev=0, run=0.
//   - locked=0, fault=0, err_pulse=0, err_cnt=0, all immediately.
// - Match definition: data_in == prev + 1, computed WIDTH-bit modulo, so prev=all-ones expects 0.
// - en=0 edges: no state change, prev/run held, err_pulse=0. Gaps of any length are legal.
// - On every en=1 edge (clear=0): prev <= data_in, whatever the state.
// - IDLE: en=1 -> ACQ, run <= 0. The first sample is never checked.
// - ACQ, en=1:
//   - match: run <= run+1; if run==LOCK_CNT-1 -> LOCKED.
//   - mismatch: run <= 0, stay in ACQ. No err_pulse.
// - LOCKED, en=1:
//   - match: stay.
//   - mismatch: -> FAULT, err_pulse=1 on the following cycle.
// - FAULT:
//   - Left only by clear or reset.
//   - Mismatches still produce err_pulse.
//   - Matches are ignored.
// - clear=1 at an edge, any state:
//   - -> IDLE, run <= 0, prev held, err_cnt <= 0.
//   - Any concurrent en sample is discarded.
// - Latency: locked/fault/err_pulse change on the same edge that samples the deciding data_in.
//   - locked rises on the edge of the (LOCK_CNT+1)-th accepted sample after IDLE, if all match.
// - locked and fault are mutually exclusive; they are never both 1.
// - Reset deasserted mid-stream: the checker restarts from IDLE; no fault is reported for the discontinuity.
//
// CONFIGURATION
// - Macro CHK_ERR_CNT_EN defined:
//   - err_cnt increments on every err_pulse event.
//   - Saturates at 2^ERR_W-1 (no wrap).
//   - Zeroed by clear or reset.
// - Macro CHK_ERR_CNT_EN undefined:
//   - err_cnt is tied to constant 0 and no counter flops are built.
//   - All other behaviour is identical.
//
// TESTING
// - Reset, en=1, feed 0,1,2,...,9 -> locked=0 through sample 3, locked=1 from the edge sampling 4; fault=0, err_pulse never 1.
// - Locked, feed 0xFC,0xFD,0xFE,0xFF,0x00,0x01 -> locked stays 1 across the 0xFF->0x00 wrap; no err_pulse.
// - Locked at 0x10, feed 0x20 -> err_pulse=1 for exactly 1 cycle, locked=0, fault=1.
//   - Then feed 0x21 -> no pulse, fault stays 1. err_cnt=1 with the macro, 0 without.
// - Alternate en=1/0 with random data_in on en=0 cycles, en=1 samples 5,6,7,8,9,10 -> locks exactly as with contiguous samples; junk ignored.
// - In FAULT, assert clear and en together with data_in=0x55 -> IDLE, fault=0, err_cnt=0.
//   - The 0x55 sample is discarded; relock then needs LOCK_CNT+1 fresh samples.
// - Locked: pull rst_n low mid-cycle -> locked=0 before the next edge.
// - With the macro, in FAULT, feed 300 mismatches -> err_cnt=0xFF and holds.

Source files
------------

// File: rtl/cnt_stream_checker.sv
// rtl/cnt_stream_checker.sv - lock-then-sticky-fault checker for a +1 counter stream (optional CHK_ERR_CNT_EN error counter)
module cnt_stream_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    output logic             locked,
    output logic             fault,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACQ    = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [1:0] S_FAULT  = 2'd3;

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             locked_q, fault_q, pulse_q;
    logic             pulse_d;
    logic [WIDTH-1:0] expect_w;
    logic             match_w;

    // Wraps naturally at WIDTH bits, so all-ones expects zero next.
    assign expect_w = prev_q + WIDTH'(1);
    assign match_w  = (data_in == expect_w);

    // Next-state decode; clear outranks any concurrent sample.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        run_d   = run_q;
        pulse_d = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            run_d   = '0;
        end else if (en) begin
            prev_d = data_in;
            case (state_q)
                S_IDLE: begin
                    state_d = S_ACQ;
                    run_d   = '0;
                end
                S_ACQ: begin
                    if (match_w) begin
                        run_d = run_q + 1'b1;
                        if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (!match_w) begin
                        state_d = S_FAULT;
                        pulse_d = 1'b1;
                    end
                end
                default: begin
                    if (!match_w) begin
                        pulse_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // State, history and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            prev_q   <= '0;
            run_q    <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            run_q    <= run_d;
            locked_q <= (state_d == S_LOCKED);
            fault_q  <= (state_d == S_FAULT);
            pulse_q  <= pulse_d;
        end
    end

    assign locked    = locked_q;
    assign fault     = fault_q;
    assign err_pulse = pulse_q;

`ifdef CHK_ERR_CNT_EN
    logic [ERR_W-1:0] err_cnt_q;

    // Saturating count of error pulses, zeroed by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (clear) begin
            err_cnt_q <= '0;
        end else if (pulse_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cnt_stream_checker.sv
// tb/tb_cnt_stream_checker.sv - randomized and directed self-checking bench for cnt_stream_checker
module tb_cnt_stream_checker;

    localparam int LOCK_CNT = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data_in;
    logic       clear;
    logic       locked;
    logic       fault;
    logic       err_pulse;
    logic [7:0] err_cnt;

    int checks;
    int errors;
    bit cmp_on;

    // Reference model: sample history summarised as "started", run length of +1 matches,
    // and the locked/faulted verdicts derived from it.
    bit       m_started;
    int       m_streak;
    bit       m_locked;
    bit       m_fault;
    bit       m_pulse;
    int       m_cnt;
    bit [7:0] m_prev;

    cnt_stream_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .data_in   (data_in),
        .clear     (clear),
        .locked    (locked),
        .fault     (fault),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_streak  = 0;
        m_locked  = 0;
        m_fault   = 0;
        m_pulse   = 0;
        m_cnt     = 0;
        m_prev    = 8'h00;
    endtask

    task automatic model_edge(input bit e, input bit [7:0] d, input bit c);
        bit [7:0] nxt;
        bit       good;
        m_pulse = 0;
        if (c) begin
            m_started = 0;
            m_streak  = 0;
            m_locked  = 0;
            m_fault   = 0;
            m_cnt     = 0;
        end else if (e) begin
            nxt  = m_prev + 8'd1;
            good = (d == nxt);
            if (!m_started) begin
                m_started = 1;
                m_streak  = 0;
            end else if (m_fault) begin
                m_pulse = !good;
            end else if (m_locked) begin
                if (!good) begin
                    m_locked = 0;
                    m_fault  = 1;
                    m_pulse  = 1;
                end
            end else begin
                m_streak = good ? m_streak + 1 : 0;
                if (m_streak >= LOCK_CNT) m_locked = 1;
            end
            m_prev = d;
`ifdef CHK_ERR_CNT_EN
            if (m_pulse && m_cnt < 255) m_cnt++;
`endif
        end
    endtask

    // One clock: present inputs, let the edge happen, advance the model.
    task automatic step(input bit e, input bit [7:0] d, input bit c);
        en      = e;
        data_in = d;
        clear   = c;
        @(posedge clk);
        model_edge(e, d, c);
        #1;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_locked", int'(locked), 0);
        chk("async_fault", int'(fault), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_locked", int'(locked), int'(m_locked));
            chk("model_fault", int'(fault), int'(m_fault));
            chk("model_err_pulse", int'(err_pulse), int'(m_pulse));
            chk("model_err_cnt", int'(err_cnt), m_cnt);
            chk("excl_locked_fault", int'(locked && fault), 0);
        end
    end

    initial begin
        int exp_cnt;
        checks  = 0;
        errors  = 0;
        cmp_on  = 0;
        en      = 1'b0;
        clear   = 1'b0;
        data_in = 8'h00;
        rst_n   = 1'b0;
        model_reset();
        #3;
        chk("rst_locked", int'(locked), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_on = 1;

        // Contiguous 0..9: lock on the edge sampling 4.
        for (int i = 0; i <= 9; i++) begin
            step(1, 8'(i), 0);
            chk("seq_locked", int'(locked), (i >= 4) ? 1 : 0);
            chk("seq_pulse", int'(err_pulse), 0);
        end

        // Wrap across 0xFF -> 0x00 while locked.
        step(0, 8'h00, 1);
        for (int i = 0; i < 11; i++) begin
            step(1, 8'(8'hF7 + i), 0);
            if (i >= 4) chk("wrap_locked", int'(locked), 1);
            chk("wrap_pulse", int'(err_pulse), 0);
        end

        // Break at 0x10 -> 0x20, then 0x21.
        step(0, 8'h00, 1);
        for (int i = 8'h0C; i <= 8'h10; i++) step(1, 8'(i), 0);
        chk("brk_pre_locked", int'(locked), 1);
        step(1, 8'h20, 0);
        chk("brk_pulse", int'(err_pulse), 1);
        chk("brk_locked", int'(locked), 0);
        chk("brk_fault", int'(fault), 1);
        step(0, 8'h00, 0);
        chk("brk_pulse_gone", int'(err_pulse), 0);
        step(1, 8'h21, 0);
        chk("brk_match_pulse", int'(err_pulse), 0);
        chk("brk_fault_hold", int'(fault), 1);
`ifdef CHK_ERR_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        chk("brk_err_cnt", int'(err_cnt), exp_cnt);

        // Clear with concurrent sample 0x55: the sample is discarded.
        step(1, 8'h55, 1);
        chk("clr_fault", int'(fault), 0);
        chk("clr_err_cnt", int'(err_cnt), 0);
        for (int i = 8'h56; i <= 8'h5A; i++) begin
            step(1, 8'(i), 0);
            chk("relock", int'(locked), (i == 8'h5A) ? 1 : 0);
        end

        // Gapped samples 5..10 with junk between.
        step(0, 8'h00, 1);
        for (int k = 5; k <= 10; k++) begin
            step(1, 8'(k), 0);
            chk("gap_locked", int'(locked), (k >= 9) ? 1 : 0);
            step(0, 8'($urandom_range(0, 255)), 0);
        end

        // Mid-cycle asynchronous reset while locked.
        async_reset();

        // Saturation: 300 mismatches in FAULT.
        for (int i = 0; i <= 4; i++) step(1, 8'(i), 0);
        for (int i = 0; i < 300; i++) step(1, 8'h77, 0);
`ifdef CHK_ERR_CNT_EN
        exp_cnt = 255;
`else
        exp_cnt = 0;
`endif
        chk("sat_err_cnt", int'(err_cnt), exp_cnt);
        step(1, 8'h77, 0);
        chk("sat_hold", int'(err_cnt), exp_cnt);

        // Randomized stream, mostly incrementing, with gaps, breaks, clears and resets.
        step(0, 8'h00, 1);
        for (int i = 0; i < 3000; i++) begin
            bit       e;
            bit       c;
            bit [7:0] d;
            if ($urandom_range(0, 999) < 4) begin
                async_reset();
            end else begin
                e = ($urandom_range(0, 99) < 75);
                c = ($urandom_range(0, 99) < 2);
                if (e && $urandom_range(0, 99) < 92) d = m_prev + 8'd1;
                else d = 8'($urandom_range(0, 255));
                step(e, d, c);
            end
        end

        cmp_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
